// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU MEM stage (priority)
// and an external loader/debug port, with a starvation counter forcing EXT grants.
module dmem_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_re,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          ext_req,
   input  logic          ext_we,
   input  logic [AW-1:0] ext_addr,
   input  logic [DW-1:0] ext_wdata,
   output logic          ext_gnt,
   output logic [DW-1:0] ext_rdata,
   output logic          ext_rvalid,
   output logic          mem_re,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, CPU, EXT_RD, EXT_WR} owner_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic          cpu_act;
   logic          ext_win;
   logic [3:0]    starve_cnt_q, starve_cnt_d;
   owner_t        owner_q, owner_d;
   logic [DW-1:0] ext_rdata_q, ext_rdata_d;

   // EXT wins an idle cycle, or any cycle once it has lost STARVE_MAX in a row.
   always_comb begin
      cpu_act = cpu_re | cpu_we;
      ext_win = ext_req & (~cpu_act | (starve_cnt_q == STARVE_LIM));
   end

   always_comb begin
      mem_addr  = ext_win ? ext_addr  : cpu_addr;
      mem_wdata = ext_win ? ext_wdata : cpu_wdata;
      mem_we    = rst & (ext_win ? ext_we  : cpu_we);
      mem_re    = rst & (ext_win ? ~ext_we : (cpu_re & ~cpu_we));
      ext_gnt   = rst & ext_win;
      cpu_stall = rst & cpu_act & ext_win;
      cpu_rdata = (cpu_act & ~ext_win) ? mem_rdata : '0;
   end

   always_comb begin
      starve_cnt_d = '0;
      if (ext_req & ~ext_win) begin
         starve_cnt_d = (starve_cnt_q >= STARVE_LIM) ? STARVE_LIM : starve_cnt_q + 4'd1;
      end
      owner_d = IDLE;
      if (ext_win) begin
         owner_d = ext_we ? EXT_WR : EXT_RD;
      end else if (cpu_act) begin
         owner_d = CPU;
      end
      ext_rdata_d = (ext_win & ~ext_we) ? mem_rdata : ext_rdata_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         starve_cnt_q <= '0;
         owner_q      <= IDLE;
         ext_rdata_q  <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         owner_q      <= owner_d;
         ext_rdata_q  <= ext_rdata_d;
      end
   end

   // Masked while reset is asserted so a read granted just before reset never surfaces.
   always_comb begin
      ext_rvalid = rst & (owner_q == EXT_RD);
      ext_rdata  = rst ? ext_rdata_q : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand-written
// starvation / reset sequences, and random traffic against a behavioural model.
module tb_dmem_arbiter;

   localparam int STARVE_MAX = 4;

   logic        clk;
   logic        rst;
   logic        cpu_re, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_stall;
   logic        ext_req, ext_we;
   logic [31:0] ext_addr, ext_wdata, ext_rdata;
   logic        ext_gnt, ext_rvalid;
   logic        mem_re, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;

   dmem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
      .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in data memory: combinational read, write on posedge.
   bit [31:0] ram [0:255];
   assign mem_rdata = ram[mem_addr[7:0]];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
   end

   typedef struct {
      logic        rst, cpuRe, cpuWe;
      logic [31:0] cpuAddr, cpuWdata;
      logic        extReq, extWe;
      logic [31:0] extAddr, extWdata;
      logic        gnt, stall, mre, mwe, rvalid;
      logic [31:0] erdata;
      logic        chkCrd;
      logic [31:0] crdata;
   } vec_t;

   // Behavioural model: count of consecutive EXT losses, pending read return, own memory copy.
   bit [31:0] refMem [0:255];
   int        losses = 0;
   bit        pendRd = 0;
   bit [31:0] refRdata = 0;
   bit        mWin;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rst       = v.rst;
      cpu_re    = v.cpuRe;
      cpu_we    = v.cpuWe;
      cpu_addr  = v.cpuAddr;
      cpu_wdata = v.cpuWdata;
      ext_req   = v.extReq;
      ext_we    = v.extWe;
      ext_addr  = v.extAddr;
      ext_wdata = v.extWdata;
      #1;
   endtask

   // Compares every output against what the model derives from the current inputs.
   task automatic checkOutput();
      bit act;
      act  = cpu_re || cpu_we;
      mWin = ext_req && (!act || losses == STARVE_MAX);
      if (!rst) begin
         check("rst_mem_re", {31'b0, mem_re}, 0);
         check("rst_mem_we", {31'b0, mem_we}, 0);
         check("rst_gnt", {31'b0, ext_gnt}, 0);
         check("rst_stall", {31'b0, cpu_stall}, 0);
      end else begin
         check("gnt", {31'b0, ext_gnt}, {31'b0, mWin});
         check("stall", {31'b0, cpu_stall}, {31'b0, act && mWin});
         check("mem_we", {31'b0, mem_we}, {31'b0, mWin ? ext_we : cpu_we});
         check("mem_re", {31'b0, mem_re}, {31'b0, mWin ? !ext_we : (cpu_re && !cpu_we)});
         if (mWin || act) check("mem_addr", mem_addr, mWin ? ext_addr : cpu_addr);
         if (mWin ? ext_we : cpu_we) check("mem_wdata", mem_wdata, mWin ? ext_wdata : cpu_wdata);
         check("cpu_rdata", cpu_rdata, (act && !mWin) ? refMem[cpu_addr[7:0]] : 32'h0);
      end
      check("rvalid", {31'b0, ext_rvalid}, {31'b0, rst && pendRd});
      check("ext_rdata", ext_rdata, rst ? refRdata : 32'h0);
   endtask

   task automatic advance();
      @(posedge clk);
      if (!rst) begin
         losses   = 0;
         pendRd   = 0;
         refRdata = 0;
      end else begin
         pendRd = mWin && !ext_we;
         if (pendRd) refRdata = refMem[ext_addr[7:0]];
         if (ext_req && !mWin) losses = (losses + 1 > STARVE_MAX) ? STARVE_MAX : losses + 1;
         else losses = 0;
         if (mWin && ext_we) refMem[ext_addr[7:0]] = ext_wdata;
         else if (!mWin && cpu_we) refMem[cpu_addr[7:0]] = cpu_wdata;
      end
      #1;
   endtask

   function automatic vec_t mk(input logic r, input logic re, input logic we,
                               input logic [31:0] ca, input logic [31:0] cw,
                               input logic er, input logic ew,
                               input logic [31:0] ea, input logic [31:0] ewd);
      vec_t v;
      v = '{r, re, we, ca, cw, er, ew, ea, ewd, 0, 0, 0, 0, 0, 0, 0, 0};
      return v;
   endfunction

   vec_t vecs [15];

   initial begin
      vec_t v;
      bit   extPending;
      int   r;

      vecs[0]  = '{0,1,1,32'h10,32'h1111,1,0,32'h10,32'h2222, 0,0,0,0,0,32'h0,0,32'h0};
      vecs[1]  = '{0,1,1,32'h10,32'h1111,1,0,32'h10,32'h2222, 0,0,0,0,0,32'h0,0,32'h0};
      vecs[2]  = '{1,0,1,32'h10,32'hDEADBEEF,0,0,32'h0,32'h0, 0,0,0,1,0,32'h0,0,32'h0};
      vecs[3]  = '{1,1,0,32'h10,32'h0,0,0,32'h0,32'h0, 0,0,1,0,0,32'h0,1,32'hDEADBEEF};
      vecs[4]  = '{1,0,0,32'h0,32'h0,0,0,32'h0,32'h0, 0,0,0,0,0,32'h0,1,32'h0};
      vecs[5]  = '{1,0,0,32'h0,32'h0,1,0,32'h10,32'h0, 1,0,1,0,0,32'h0,1,32'h0};
      vecs[6]  = '{1,0,0,32'h0,32'h0,0,0,32'h0,32'h0, 0,0,0,0,1,32'hDEADBEEF,1,32'h0};
      vecs[7]  = '{1,0,0,32'h0,32'h0,0,0,32'h0,32'h0, 0,0,0,0,0,32'hDEADBEEF,1,32'h0};
      vecs[8]  = '{1,1,1,32'h20,32'h12345678,0,0,32'h0,32'h0, 0,0,0,1,0,32'hDEADBEEF,0,32'h0};
      vecs[9]  = '{1,1,0,32'h20,32'h0,0,0,32'h0,32'h0, 0,0,1,0,0,32'hDEADBEEF,1,32'h12345678};
      vecs[10] = '{1,0,0,32'h0,32'h0,1,1,32'h30,32'hA5A5A5A5, 1,0,0,1,0,32'hDEADBEEF,1,32'h0};
      vecs[11] = '{1,1,0,32'h30,32'h0,0,0,32'h0,32'h0, 0,0,1,0,0,32'hDEADBEEF,1,32'hA5A5A5A5};
      vecs[12] = '{1,1,0,32'h30,32'h0,1,0,32'h10,32'h0, 0,0,1,0,0,32'hDEADBEEF,1,32'hA5A5A5A5};
      vecs[13] = '{1,0,0,32'h0,32'h0,1,0,32'h10,32'h0, 1,0,1,0,0,32'hDEADBEEF,1,32'h0};
      vecs[14] = '{1,0,0,32'h0,32'h0,0,0,32'h0,32'h0, 0,0,0,0,1,32'hDEADBEEF,1,32'h0};

      // Power-up: one reset edge with every request high, so registers are defined.
      applyStimulus(vecs[0]);
      @(posedge clk);
      #1;

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i]);
         checkOutput();
         check($sformatf("vec%0d_gnt", i), {31'b0, ext_gnt}, {31'b0, vecs[i].gnt});
         check($sformatf("vec%0d_stall", i), {31'b0, cpu_stall}, {31'b0, vecs[i].stall});
         check($sformatf("vec%0d_mem_re", i), {31'b0, mem_re}, {31'b0, vecs[i].mre});
         check($sformatf("vec%0d_mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].mwe});
         check($sformatf("vec%0d_rvalid", i), {31'b0, ext_rvalid}, {31'b0, vecs[i].rvalid});
         check($sformatf("vec%0d_ext_rdata", i), ext_rdata, vecs[i].erdata);
         if (vecs[i].chkCrd) check($sformatf("vec%0d_cpu_rdata", i), cpu_rdata, vecs[i].crdata);
         advance();
      end

      // Starvation: continuous CPU reads vs continuous EXT reads; EXT wins every fifth cycle.
      for (int i = 0; i < 15; i++) begin
         applyStimulus(mk(1, 1, 0, 32'h30, 32'h0, 1, 0, 32'h10, 32'h0));
         checkOutput();
         check($sformatf("starve%0d_gnt", i), {31'b0, ext_gnt}, {31'b0, (i % 5) == 4});
         check($sformatf("starve%0d_stall", i), {31'b0, cpu_stall}, {31'b0, (i % 5) == 4});
         check($sformatf("starve%0d_mem_re", i), {31'b0, mem_re}, 32'h1);
         advance();
      end

      // Reset right after an EXT read grant: the return must never appear.
      applyStimulus(mk(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0));
      checkOutput();
      check("rstrd_gnt", {31'b0, ext_gnt}, 32'h1);
      advance();
      applyStimulus(mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0));
      checkOutput();
      check("rstrd_rvalid_in_rst", {31'b0, ext_rvalid}, 32'h0);
      check("rstrd_rdata_in_rst", ext_rdata, 32'h0);
      advance();
      applyStimulus(mk(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0));
      checkOutput();
      check("rstrd_rvalid_after", {31'b0, ext_rvalid}, 32'h0);
      check("rstrd_rdata_after", ext_rdata, 32'h0);
      advance();

      // Random traffic, EXT side follows the hold-until-granted protocol.
      extPending = 0;
      v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 400; n++) begin
         v.rst = ($urandom_range(0, 49) != 0);
         r = $urandom_range(0, 3);
         v.cpuRe    = (r == 1) || (r == 3);
         v.cpuWe    = (r == 2) || (r == 3);
         v.cpuAddr  = $urandom_range(0, 255);
         v.cpuWdata = $urandom;
         if (!extPending && $urandom_range(0, 2) == 0) begin
            extPending = 1;
            v.extWe    = $urandom_range(0, 1);
            v.extAddr  = $urandom_range(0, 255);
            v.extWdata = $urandom;
         end
         v.extReq = extPending;
         applyStimulus(v);
         checkOutput();
         if (mWin && rst) extPending = 0;
         advance();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline MEM stage (CPU port) and an external loader/debug port (EXT port).
- The CPU has priority. A starvation counter guarantees EXT forward progress, and the CPU stalls on those cycles.
- Sits between the MEM stage and the Dmem instance.
- Memory read is combinational: mem_rdata is valid in the same cycle that mem_addr/mem_re are driven.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_MAX, 4, number of consecutive lost EXT cycles before EXT is forced a grant. Legal range is 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-low: state clears on the posedge where rst==0.
- cpu_re  in  1  MEM-stage read request.
- cpu_we  in  1  MEM-stage write request.
- cpu_addr  in  AW  MEM-stage address (ALU result).
- cpu_wdata  in  DW  MEM-stage store data.
- cpu_rdata  out  DW  load data to the pipeline; combinational.
- cpu_stall  out  1  freeze the pipeline this cycle; the CPU access was not performed.
- ext_req  in  1  EXT access request; held until granted.
- ext_we  in  1  1 = write, 0 = read; stable while ext_req is high.
- ext_addr  in  AW  EXT address.
- ext_wdata  in  DW  EXT write data.
- ext_gnt  out  1  EXT access issued this cycle; combinational.
- ext_rdata  out  DW  registered EXT read data.
- ext_rvalid  out  1  one-cycle pulse, the cycle after an EXT read grant.
- mem_re  out  1  to Dmem.
- mem_we  out  1  to Dmem.
- mem_addr  out  AW  to Dmem.
- mem_wdata  out  DW  to Dmem.
- mem_rdata  in  DW  from Dmem.

Behaviour:
- Definition: cpu_act = cpu_re | cpu_we.
- Simultaneous cpu_re and cpu_we: treated as a write; mem_re=0.

Grant decision (combinational, each cycle):
- ext_win = ext_req & (~cpu_act | (starve_cnt == STARVE_MAX)).
- ext_gnt = ext_win & rst.

Memory mux:
- If ext_win: mem_addr=ext_addr, mem_wdata=ext_wdata, mem_we=ext_we, mem_re=~ext_we.
- Else: the CPU signals pass through, with mem_re = cpu_re & ~cpu_we.
- When rst==0: mem_re=0, mem_we=0, ext_gnt=0, cpu_stall=0.

Stall and CPU data:
- cpu_stall = cpu_act & ext_win.
- cpu_rdata = mem_rdata when the CPU owns the memory, else 0.

starve_cnt (registered, 4 bits):
- Reset to 0.
- If ext_req & ~ext_win: increment, saturating at STARVE_MAX.
- Else: clear to 0. This covers both a grant and ext_req being low.

Owner FSM (registered; states IDLE, CPU, EXT_RD, EXT_WR), records the previous cycle's issue:
- EXT_RD if ext_win & ~ext_we.
- EXT_WR if ext_win & ext_we.
- CPU if cpu_act & ~ext_win.
- IDLE otherwise.

EXT read return:
- On the posedge after an EXT read grant: ext_rdata <= mem_rdata (captured at that same edge, i.e. the grant-cycle data), and ext_rvalid=1 for one cycle.
- ext_rdata holds its value until the next EXT read.

Timing and boundaries:
- EXT latency: grant in cycle N, data/rvalid in cycle N+1.
- Back-to-back EXT reads give rvalid on consecutive cycles.
- A stalled CPU re-presents the same request. On the next cycle the CPU wins, because starve_cnt was cleared.
- A forced EXT grant leaves exactly one stall cycle; EXT can then win again only after another STARVE_MAX losses.
- Reset (rst==0) mid-operation: starve_cnt=0, owner=IDLE, ext_rvalid=0, ext_rdata=0. A pending rvalid from a grant in the cycle before reset is suppressed.
- Reset values: every registered output is 0.

Test Plan:
- Reset: hold rst=0 for 2 cycles with all requests high -> mem_we=0, mem_re=0, ext_gnt=0, cpu_stall=0, ext_rvalid=0, ext_rdata=0.
- CPU only: cpu_we=1, addr=0x10, wdata=0xDEADBEEF, then cpu_re=1 at addr 0x10 -> mem_we pulse with those values; cpu_rdata=0xDEADBEEF; cpu_stall=0 throughout.
- EXT only: ext_req with ext_we=0 at addr 0x10, memory holding 0xDEADBEEF -> ext_gnt high the same cycle; next cycle ext_rvalid=1 and ext_rdata=0xDEADBEEF; then ext_rvalid=0 with data held.
- Starvation: cpu_re=1 continuously, ext_req=1 continuously, STARVE_MAX=4 -> ext_gnt is 0 for 4 cycles, then 1 in cycle 5 with cpu_stall=1 in cycle 5 only; the pattern repeats every 5 cycles.
- Write precedence: cpu_re=1 and cpu_we=1 together -> mem_we=1, mem_re=0.
- Reset mid-read: EXT read granted in cycle N, rst=0 at posedge N+1 -> ext_rvalid stays 0 and ext_rdata=0.
